// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed data memory for the load/store stage.
// Word-crossing accesses are split into two beats by a small FSM.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS      = 256,
    parameter bit          ALLOW_MISALIGNED = 1'b1,
    parameter string       INIT_FILE        = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic [31:0] dbg_addr,
    output logic [31:0] dbg_data
);

    localparam int unsigned AW =
        (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BYTE_CAP =
        {1'b0, 32'(4 * DEPTH_WORDS)};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BEAT2 = 1'b1
    } state_t;

    logic [31:0] mem_q [DEPTH_WORDS];

    state_t      state_q, state_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    // Context carried from beat 1 into beat 2 of a split access.
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    lane_q, lane_d;
    logic [AW-1:0] idx2_q, idx2_d;
    logic [3:0]    be2_q, be2_d;
    logic [31:0]   wd2_q, wd2_d;
    logic [31:0]   lo_q, lo_d;

    logic [2:0]    nbytes;
    logic [3:0]    nmask;
    logic [1:0]    lane;
    logic [32:0]   last_byte;
    logic          size_err;
    logic          range_err;
    logic          misaligned;
    logic          req_err;
    logic          crosses;
    logic          split;
    logic [7:0]    be_wide;
    logic [63:0]   wd_wide;
    logic [AW-1:0] idx1;
    logic [AW-1:0] idx1_next;
    logic [31:0]   rd_word;
    logic [31:0]   hi_word;
    logic [63:0]   pair;
    logic [31:0]   single_raw;

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;

    logic          dbg_in_range;
    logic          unused_bits;

    // Sign or zero extend the low byte/half of a raw load word.
    function automatic logic [31:0] extend(
        input logic [31:0] raw,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [31:0] r;
        unique case (size)
            2'b00:   r = {{24{raw[7] & ~uns}}, raw[7:0]};
            2'b01:   r = {{16{raw[15] & ~uns}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Access width and lane mask from the request size.
    always_comb begin
        nbytes = 3'd4;
        nmask  = 4'b1111;
        unique case (req_size)
            2'b00: begin
                nbytes = 3'd1;
                nmask  = 4'b0001;
            end
            2'b01: begin
                nbytes = 3'd2;
                nmask  = 4'b0011;
            end
            default: ;
        endcase
    end

    assign lane      = req_addr[1:0];
    // 33-bit sum so an access wrapping past 0xFFFFFFFF faults.
    assign last_byte = {1'b0, req_addr} + {30'd0, nbytes} - 33'd1;
    assign size_err  = (req_size == 2'b11);
    assign range_err = (last_byte >= BYTE_CAP);
    assign misaligned =
        ((req_size == 2'b01) && req_addr[0]) ||
        ((req_size == 2'b10) && (lane != 2'b00));
    assign req_err =
        size_err || range_err || (!ALLOW_MISALIGNED && misaligned);
    assign crosses = (({1'b0, lane} + nbytes) > 3'd4);
    assign split   = !req_err && crosses;

    // Lanes/data of the request laid across words W (low) and W+1 (high).
    assign be_wide = {4'b0000, nmask} << lane;
    assign wd_wide = {32'd0, req_wdata} << {lane, 3'b000};

    assign idx1       = req_addr[AW+1:2];
    assign idx1_next  = idx1 + AW'(1);
    assign rd_word    = mem_q[idx1];
    assign hi_word    = mem_q[idx2_q];
    assign pair       = {hi_word, lo_q} >> {lane_q, 3'b000};
    assign single_raw = rd_word >> {lane, 3'b000};

    assign req_ready = (state_q == S_IDLE);

    // Next state, beat sequencing, memory write port and response.
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lane_d      = lane_q;
        idx2_d      = idx2_q;
        be2_d       = be2_q;
        wd2_d       = wd2_q;
        lo_d        = lo_q;
        wr_en       = 1'b0;
        wr_idx      = idx1;
        wr_be       = be_wide[3:0];
        wr_data     = wd_wide[31:0];
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        wr_en = req_we;
                        if (split) begin
                            state_d = S_BEAT2;
                            we_d    = req_we;
                            size_d  = req_size;
                            uns_d   = req_unsigned;
                            lane_d  = lane;
                            idx2_d  = idx1_next;
                            be2_d   = be_wide[7:4];
                            wd2_d   = wd_wide[63:32];
                            lo_d    = rd_word;
                        end else begin
                            rsp_valid_d = 1'b1;
                            if (!req_we) begin
                                rsp_rdata_d = extend(
                                    single_raw, req_size,
                                    req_unsigned);
                            end
                        end
                    end
                end
            end
            S_BEAT2: begin
                state_d     = S_IDLE;
                wr_en       = we_q;
                wr_idx      = idx2_q;
                wr_be       = be2_q;
                wr_data     = wd2_q;
                rsp_valid_d = 1'b1;
                if (!we_q) begin
                    rsp_rdata_d = extend(pair[31:0], size_q, uns_q);
                end
            end
            default: ;
        endcase
    end

    // State, response and split-context registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            lane_q      <= '0;
            idx2_q      <= '0;
            be2_q       <= '0;
            wd2_q       <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            idx2_q      <= idx2_d;
            be2_q       <= be2_d;
            wd2_q       <= wd2_d;
            lo_q        <= lo_d;
        end
    end

    // Byte-lane write; reset blocks writes but never clears contents.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    assign dbg_in_range =
        ({2'b00, dbg_addr[31:2]} < 32'(DEPTH_WORDS));
    assign dbg_data =
        dbg_in_range ? mem_q[dbg_addr[AW+1:2]] : '0;

    assign unused_bits = ^{dbg_addr[1:0], pair[63:32]};

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: vector table plus scoreboard for data_mem_ctrl.
// A second instance covers the misaligned-as-error configuration.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid_al = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] dbg_addr = 32'd0;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, dbg_data;
    logic        req_ready_al, rsp_valid_al, rsp_err_al;
    logic [31:0] rsp_rdata_al, dbg_data_al;

    data_mem_ctrl #(
        .DEPTH_WORDS(256),
        .ALLOW_MISALIGNED(1'b1),
        .INIT_FILE("")
    ) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    data_mem_ctrl #(
        .DEPTH_WORDS(256),
        .ALLOW_MISALIGNED(1'b0),
        .INIT_FILE("")
    ) u_dut_al (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_al), .req_ready(req_ready_al),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_al), .rsp_rdata(rsp_rdata_al),
        .rsp_err(rsp_err_al),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_al)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int first_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
        logic        spl;
    } vec_t;

    vec_t vt [40];
    int   nv = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h",
                     name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wd, input logic err,
                       input logic [31:0] rd, input logic spl);
        vt[nv] = '{we, sz, uns, addr, wd, err, rd, spl};
        nv++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic do_req(input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] wd, input logic e_err,
                          input logic [31:0] e_rd, input logic spl,
                          input string tag);
        int n = 0;
        while (!req_ready && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            chk({tag, "_ready_timeout"}, {31'd0, req_ready}, 32'd1);
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        sb.push_back('{cyc + (spl ? 2 : 1), e_err, e_rd, tag});
        @(posedge clk);
        #1;
        last_acc  = cyc;
        req_valid = 1'b0;
    endtask

    task automatic al_req(input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic e_err, input logic [31:0] e_rd,
                          input string tag);
        req_valid_al = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = 1'b0;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid_al = 1'b0;
        chk({tag, "_valid"}, {31'd0, rsp_valid_al}, 32'd1);
        chk({tag, "_err"}, {31'd0, rsp_err_al}, {31'd0, e_err});
        chk({tag, "_rdata"}, rsp_rdata_al, e_rd);
    endtask

    task automatic dbg_chk(input logic [31:0] a,
                           input logic [31:0] exp, input string tag);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Scoreboard: compare every response and flag missing ones.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, "_err"}, {31'd0, rsp_err},
                    {31'd0, mon_e.err});
                chk({mon_e.tag, "_rdata"}, rsp_rdata, mon_e.rdata);
                chk({mon_e.tag, "_cycle"}, cyc, mon_e.due);
            end
        end else if (sb.size() != 0 && sb[0].due < cyc) begin
            chk({sb[0].tag, "_missing_rsp"},
                {31'd0, rsp_valid}, 32'd1);
            void'(sb.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b1;

        // we sz uns addr wdata err rdata split
        add(1, 2, 0, 'h000, 'h13579BDF, 0, 0, 0);
        add(1, 2, 0, 'h010, 'h800000FF, 0, 0, 0);
        add(0, 2, 0, 'h010, 0, 0, 'h800000FF, 0);
        add(0, 0, 0, 'h010, 0, 0, 'hFFFFFFFF, 0);
        add(0, 0, 1, 'h010, 0, 0, 'h000000FF, 0);
        add(0, 1, 0, 'h012, 0, 0, 'hFFFF8000, 0);
        add(0, 1, 1, 'h012, 0, 0, 'h00008000, 0);
        add(1, 0, 0, 'h011, 'h123456AA, 0, 0, 0);
        add(0, 2, 0, 'h010, 0, 0, 'h8000AAFF, 0);
        add(1, 2, 0, 'h00C, 'hA5A5A5A5, 0, 0, 0);
        add(1, 2, 0, 'h00E, 'h11223344, 0, 0, 1);
        add(0, 2, 0, 'h00C, 0, 0, 'h3344A5A5, 0);
        add(0, 2, 0, 'h010, 0, 0, 'h80001122, 0);
        add(0, 2, 0, 'h00E, 0, 0, 'h11223344, 1);
        add(0, 1, 0, 'h00F, 0, 0, 'h00002233, 1);
        add(0, 0, 0, 'h00F, 0, 0, 'h00000033, 0);
        add(0, 1, 1, 'h00D, 0, 0, 'h000044A5, 0);
        add(1, 1, 0, 'h013, 'h0000BEEF, 0, 0, 1);
        add(0, 1, 0, 'h013, 0, 0, 'hFFFFBEEF, 1);
        add(0, 1, 1, 'h013, 0, 0, 'h0000BEEF, 1);
        add(0, 2, 0, 'h010, 0, 0, 'hEF001122, 0);
        add(1, 2, 0, 'h3FC, 'hCAFEF00D, 0, 0, 0);
        add(0, 2, 0, 'h3FC, 0, 0, 'hCAFEF00D, 0);
        add(0, 0, 0, 'h3FF, 0, 0, 'hFFFFFFCA, 0);
        add(0, 1, 1, 'h3FE, 0, 0, 'h0000CAFE, 0);
        add(0, 1, 0, 'h3FF, 0, 1, 0, 0);
        add(0, 2, 0, 'h3FE, 0, 1, 0, 0);
        add(1, 2, 0, 'h3FE, 'hFFFFFFFF, 1, 0, 0);
        add(1, 2, 0, 'hFFFFFFFE, 'h12345678, 1, 0, 0);
        add(0, 3, 0, 'h020, 0, 1, 0, 0);
        add(1, 3, 0, 'h3FC, 'h00000000, 1, 0, 0);
        add(1, 0, 0, 'h400, 'h00000055, 1, 0, 0);
        add(0, 2, 0, 'h3FC, 0, 0, 'hCAFEF00D, 0);
        add(0, 2, 0, 'h000, 0, 0, 'h13579BDF, 0);

        for (int i = 0; i < nv; i++) begin
            do_req(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr,
                   vt[i].wd, vt[i].err, vt[i].rd, vt[i].spl,
                   $sformatf("v%0d", i));
        end
        repeat (3) @(posedge clk);
        #1;

        // Debug port contents and range
        dbg_chk('h010, 'hEF001122, "dbg_w10");
        dbg_chk('h013, 'hEF001122, "dbg_lowbits");
        dbg_chk('h00C, 'h3344A5A5, "dbg_w0c");
        dbg_chk('h3FC, 'hCAFEF00D, "dbg_last");
        dbg_chk('h400, 'h00000000, "dbg_oob");
        dbg_chk('hFFFFFFFC, 'h00000000, "dbg_top");

        // Debug view updates at the write edge itself
        dbg_addr = 'h030;
        do_req(1, 2, 0, 'h030, 'h0F0E0D0C, 0, 0, 0, "st30");
        chk("dbg_same_edge", dbg_data, 'h0F0E0D0C);

        // Split blocks acceptance for exactly one cycle
        do_req(1, 2, 0, 'h022, 'h01020304, 0, 0, 1, "split_rdy");
        chk("split_ready_low", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("split_ready_back", {31'd0, req_ready}, 32'd1);

        // Eight back-to-back aligned requests, store then load
        for (int i = 0; i < 4; i++) begin
            do_req(1, 2, 0, 'h100 + 4 * i, 'h0BAD0000 + i, 0, 0, 0,
                   $sformatf("b2b_st%0d", i));
            if (i == 0) first_acc = last_acc;
            do_req(0, 2, 0, 'h100 + 4 * i, 0, 0, 'h0BAD0000 + i, 0,
                   $sformatf("b2b_ld%0d", i));
        end
        chk("b2b_span", last_acc - first_acc, 7);

        // Request presented during reset is ignored
        do_req(1, 2, 0, 'h040, 'h01020304, 0, 0, 0, "st40");
        rst       = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 'h040;
        req_wdata = 'hDEADBEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        chk("rstreq_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        dbg_chk('h040, 'h01020304, "rstreq_no_write");

        // Reset during BEAT2 of a split store
        do_req(1, 2, 0, 'h1FC, 'h11111111, 0, 0, 0, "pre1fc");
        do_req(1, 2, 0, 'h200, 'h22222222, 0, 0, 0, "pre200");
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 'h1FE;
        req_wdata = 'hAABBCCDD;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        chk("midsplit_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midsplit_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("midsplit_rsp_rdata", rsp_rdata, 32'd0);
        rst = 1'b1;
        chk("midsplit_ready", {31'd0, req_ready}, 32'd1);
        dbg_chk('h1FC, 'hCCDD1111, "midsplit_beat1");
        dbg_chk('h200, 'h22222222, "midsplit_beat2");
        @(posedge clk);
        #1;

        // Misaligned-as-error configuration
        chk("al_ready", {31'd0, req_ready_al}, 32'd1);
        al_req(1, 2, 'h004, 'h55667788, 0, 0, "al_sw04");
        al_req(0, 1, 'h001, 0, 1, 0, "al_lh01");
        al_req(0, 2, 'h006, 0, 1, 0, "al_lw06");
        al_req(1, 1, 'h003, 'h0000FFFF, 1, 0, "al_sh03");
        al_req(0, 2, 'h004, 0, 0, 'h55667788, "al_lw04");
        al_req(0, 1, 'h006, 0, 0, 'h00005566, "al_lh06");
        dbg_addr = 'h004;
        #1;
        chk("al_dbg04", dbg_data_al, 'h55667788);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
